exec_unit: RTL and testbench

Execute stage directly downstream of the 8-entry register file. It consumes the Adata/Bdata read ports, computes an ALU or iterative multiply/divide result, and drives the register file write port (Load, DS, Ddata) for one cycle. Single-cycle ops retire in 1 cycle; MUL/DIV use an 8-iteration sequential engine. A start/busy/done handshake lets the controller sequence instructions.

---
 rtl/exec_pkg.sv | 23 ++
 rtl/exec_unit_seq_muldiv.sv | 81 ++++++++
 rtl/exec_unit.sv | 125 ++++++++++++
 tb/tb_exec_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: op codes, FSM encoding and the
// default data/address widths that must match the register file.
package exec_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/exec_unit_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one step per cycle.
// finish pulses for one cycle once the last step has landed in result.
module seq_muldiv
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             hi_nz,
  output logic             finish
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  // hi: upper product half / partial remainder; lo: multiplier / quotient
  logic [WIDTH-1:0] hi_q, lo_q, b_q, hi_d, lo_d;
  logic [WIDTH:0]   sum, shifted, diff;
  logic             div_q, run_q;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (div_q) begin
      // diff[WIDTH] is the borrow: set when the shifted remainder is below b
      hi_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // NOTE: datapath registers carry no reset; run_q/finish qualify them.
  always_ff @(posedge clk) begin
    if (go) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= is_div;
    end else if (run_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      finish <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (go) begin
        run_q <= 1'b1;
        cnt_q <= '0;
      end else if (run_q) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          run_q  <= 1'b0;
          finish <= 1'b1;
        end
      end
    end
  end

  assign result = lo_q;
  assign hi_nz  = |hi_q;

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU inline, MUL/DIV via seq_muldiv, and a
// registered one-cycle write-back onto the register file write port.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] Adata,
  input  logic [WIDTH-1:0] Bdata,
  output logic             Load,
  output logic [AW-1:0]    DS,
  output logic [WIDTH-1:0] Ddata,
  output logic             busy,
  output logic             done,
  output logic             zflag,
  output logic             cflag
);

  state_e           state_q, state_d;
  logic             accept, go;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [AW-1:0]    dest_q;
  logic             mul_q;
  logic [WIDTH-1:0] md_result;
  logic             md_hi_nz, md_finish;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: {alu_c, alu_res} = {1'b0, Adata} + {1'b0, Bdata};
      OP_SUB: {alu_c, alu_res} = {1'b0, Adata} - {1'b0, Bdata};
      OP_AND: alu_res = Adata & Bdata;
      OP_OR:  alu_res = Adata | Bdata;
      OP_XOR: alu_res = Adata ^ Bdata;
      OP_SHL: {alu_c, alu_res} = {Adata, 1'b0};
      default: begin
        // only DIV-by-zero retires through this path
        alu_res = '1;
        alu_c   = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = start && (state_q == S_IDLE);
    go      = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        if (op == OP_MUL || (op == OP_DIV && Bdata != '0)) begin
          state_d = S_ITER;
          go      = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_ITER:  if (md_finish) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dest_q  <= '0;
      mul_q   <= 1'b0;
      Load    <= 1'b0;
      DS      <= '0;
      Ddata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      zflag   <= 1'b0;
      cflag   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
      Load    <= 1'b0;
      done    <= 1'b0;
      if (accept) begin
        dest_q <= dest;
        mul_q  <= (op == OP_MUL);
        busy   <= 1'b1;
      end
      if (state_q == S_WB) busy <= 1'b0;
      if (accept && state_d == S_WB) begin
        Load  <= 1'b1;
        done  <= 1'b1;
        DS    <= dest;
        Ddata <= alu_res;
        zflag <= (alu_res == '0);
        cflag <= alu_c;
      end else if (state_q == S_ITER && md_finish) begin
        Load  <= 1'b1;
        done  <= 1'b1;
        DS    <= dest_q;
        Ddata <= md_result;
        zflag <= (md_result == '0);
        cflag <= mul_q & md_hi_nz;
      end
    end
  end

  seq_muldiv #(.WIDTH(WIDTH), .ITER(ITER)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .is_div (op == OP_DIV),
    .a      (Adata),
    .b      (Bdata),
    .result (md_result),
    .hi_nz  (md_hi_nz),
    .finish (md_finish)
  );

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU ops, MUL/DIV latency, ignored starts,
// back-to-back accept and mid-iteration reset.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [2:0] op, dest;
  logic [7:0] Adata, Bdata;
  logic       Load, busy, done, zflag, cflag;
  logic [2:0] DS;
  logic [7:0] Ddata;

  int n_checks = 0;
  int n_err    = 0;

  exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .dest  (dest),
    .Adata (Adata),
    .Bdata (Bdata),
    .Load  (Load),
    .DS    (DS),
    .Ddata (Ddata),
    .busy  (busy),
    .done  (done),
    .zflag (zflag),
    .cflag (cflag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, watch 16 cycles.
  // lat = cycles after the accept cycle until Load; inj = cycle to pulse a stray ADD start.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] d,
                        input logic [7:0] a, input logic [7:0] b, input int lat,
                        input logic [7:0] ed, input logic ez, input logic ec, input int inj);
    int loads, first, busy_n;
    logic [7:0] gd;
    logic [2:0] gds;
    logic gz, gc, gdone;
    loads = 0; first = -1; busy_n = 0;
    gd = '0; gds = '0; gz = 1'b0; gc = 1'b0; gdone = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; dest = d; Adata = a; Bdata = b;
    @(negedge clk);
    start = 1'b0; Adata = ~a; Bdata = ~b; op = ~o; dest = ~d;
    for (int i = 0; i < 16; i++) begin
      if (busy) busy_n++;
      if (Load) begin
        if (first < 0) begin
          first = i; gd = Ddata; gds = DS; gz = zflag; gc = cflag; gdone = done;
        end
        loads++;
      end
      if (i == inj) begin
        start = 1'b1; op = 3'b000; dest = 3'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, " loads"}, loads, 1);
    check({tag, " latency"}, first, lat);
    check({tag, " busy_cycles"}, busy_n, lat + 1);
    check({tag, " DS"}, gds, d);
    check({tag, " Ddata"}, gd, ed);
    check({tag, " zflag"}, gz, ez);
    check({tag, " cflag"}, gc, ec);
    check({tag, " done"}, gdone, 1'b1);
  endtask

  initial begin
    int loads;
    rst_n = 1'b0; start = 1'b0; op = '0; dest = '0; Adata = '0; Bdata = '0;
    repeat (2) @(negedge clk);
    check("rst Load", Load, 1'b0);
    check("rst DS", DS, 3'd0);
    check("rst Ddata", Ddata, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst flags", {zflag, cflag}, 2'b00);
    rst_n = 1'b1;

    run_op("add1", 3'b000, 3'd3, 8'h7F, 8'h01, 0, 8'h80, 1'b0, 1'b0, -1);
    run_op("add2", 3'b000, 3'd4, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1, -1);
    run_op("sub1", 3'b001, 3'd2, 8'h05, 8'h05, 0, 8'h00, 1'b1, 1'b0, -1);
    run_op("sub2", 3'b001, 3'd5, 8'h03, 8'h05, 0, 8'hFE, 1'b0, 1'b1, -1);
    run_op("and",  3'b010, 3'd1, 8'hF0, 8'h3C, 0, 8'h30, 1'b0, 1'b0, -1);
    run_op("xor",  3'b100, 3'd7, 8'hFF, 8'h0F, 0, 8'hF0, 1'b0, 1'b0, -1);
    run_op("shl",  3'b101, 3'd0, 8'h81, 8'h55, 0, 8'h02, 1'b0, 1'b1, -1);
    run_op("mul1", 3'b110, 3'd6, 8'h12, 8'h0E, 9, 8'hFC, 1'b0, 1'b0, -1);
    run_op("mul2", 3'b110, 3'd2, 8'h10, 8'h10, 9, 8'h00, 1'b1, 1'b1, -1);
    run_op("div1", 3'b111, 3'd3, 8'd200, 8'd7, 9, 8'h1C, 1'b0, 1'b0, -1);
    run_op("div0", 3'b111, 3'd4, 8'h40, 8'h00, 0, 8'hFF, 1'b0, 1'b1, -1);
    run_op("mulinj", 3'b110, 3'd2, 8'h03, 8'h04, 9, 8'h0C, 1'b0, 1'b0, 3);

    // start held high through WB: second op accepted on the first IDLE edge
    @(negedge clk);
    start = 1'b1; op = 3'b000; dest = 3'd4; Adata = 8'h01; Bdata = 8'h01;
    @(negedge clk);
    check("b2b first Load", Load, 1'b1);
    check("b2b first Ddata", {DS, Ddata}, {3'd4, 8'h02});
    op = 3'b011; dest = 3'd5; Adata = 8'hF0; Bdata = 8'h0F;
    @(negedge clk);
    check("b2b idle busy/Load", {busy, Load}, 2'b00);
    @(negedge clk);
    start = 1'b0;
    check("b2b second Load", Load, 1'b1);
    check("b2b second data", {DS, Ddata, zflag, cflag}, {3'd5, 8'hFF, 2'b00});
    @(negedge clk);
    check("b2b no repeat", Load, 1'b0);

    // DIV-by-zero leaves cflag=1 so the reset check below is meaningful
    run_op("div0b", 3'b111, 3'd6, 8'h11, 8'h00, 0, 8'hFF, 1'b0, 1'b1, -1);
    @(negedge clk);
    start = 1'b1; op = 3'b110; dest = 3'd7; Adata = 8'h03; Bdata = 8'h05;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst busy/Load/done", {busy, Load, done}, 3'b000);
    check("midrst flags", {zflag, cflag}, 2'b00);
    check("midrst DS/Ddata", {DS, Ddata}, 11'd0);
    loads = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (Load) loads++;
    end
    check("midrst no write", loads, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
